// File: rtl/tqv_peri_pkg.sv
// Shared types and constants for the TinyQV peripheral bus initiator.
// Size codes, FSM state encoding, request payload and the size-to-mask helper.
package tqv_peri_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_8    = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_16   = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_32   = 2'b10;
  localparam logic [SIZE_W-1:0] SIZE_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Mask of meaningful data bits for a transfer size; SIZE_NONE yields no bits.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] m;
    m = '0;
    case (size)
      SIZE_8:  m = 32'h0000_00FF;
      SIZE_16: m = 32'h0000_FFFF;
      SIZE_32: m = 32'hFFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tqv_peri_init_timer.sv
// Read-wait timeout counter: cleared on request accept, counts while enabled.
// Expired is asserted during the TIMEOUT_CYCLES-th enabled cycle; constant 0 when TIMEOUT_CYCLES==0.
module tqv_peri_init_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expired_c = 1'b0;
    end else begin : g_on
      logic [TMO_W-1:0] r_count;

      // r_count holds the number of enabled cycles already completed.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en && !o_expired_c) begin
          r_count <= r_count + TMO_W'(1);
        end
      end

      assign o_expired_c = i_en && (r_count >= TMO_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/tqv_peri_initiator.sv
// TinyQV peripheral bus initiator: one valid/ready request -> one bus transaction -> one response.
// Optional build macro TQV_INIT_ALIGN_CHECK_EN rejects misaligned 16b/32b requests without bus activity.
module tqv_peri_initiator
  import tqv_peri_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [SIZE_W-1:0] bus_data_write_n,
  output logic [SIZE_W-1:0] bus_data_read_n,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              bus_data_ready,
  output logic              bus_data_read_complete
);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SIZE_W-1:0] r_size;
  logic [SIZE_W-1:0] r_write_n;
  logic [SIZE_W-1:0] r_read_n;
  logic              r_complete;

  req_t              w_req;
  logic              w_accept;
  logic              w_misalign;
  logic              w_bad_req;
  logic              w_tmo_en;
  logic              w_expired;

  assign w_req = '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata};
  assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

`ifdef TQV_INIT_ALIGN_CHECK_EN
  assign w_misalign = ((w_req.size == SIZE_16) && w_req.addr[0]) ||
                      ((w_req.size == SIZE_32) && (w_req.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Requests that are answered with an error and never reach the bus.
  assign w_bad_req = (w_req.size == SIZE_NONE) || w_misalign;

  assign w_tmo_en = (r_state == ST_RD_WAIT);

  tqv_peri_init_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_W         (TMO_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_en       (w_tmo_en),
    .o_expired_c(w_expired)
  );

  // Transaction FSM; every bus and response output is a register updated on the state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= SIZE_NONE;
      r_write_n   <= SIZE_NONE;
      r_read_n    <= SIZE_NONE;
      r_complete  <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= w_req.addr;
            r_wdata     <= w_req.wdata;
            r_size      <= w_req.size;
            r_req_ready <= 1'b0;
            if (w_bad_req) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (w_req.write) begin
              r_state   <= ST_WRITE;
              r_write_n <= w_req.size;
            end else begin
              r_state  <= ST_RD_WAIT;
              r_read_n <= w_req.size;
            end
          end
        end

        ST_WRITE: begin
          r_write_n   <= SIZE_NONE;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
        end

        // Ready has priority over a timeout landing in the same cycle.
        ST_RD_WAIT: begin
          if (bus_data_ready) begin
            r_rsp_rdata <= bus_data_in & size_mask(r_size);
            r_rsp_error <= 1'b0;
            r_read_n    <= SIZE_NONE;
            r_complete  <= 1'b1;
            r_state     <= ST_RD_DONE;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b1;
            r_read_n    <= SIZE_NONE;
            r_complete  <= 1'b1;
            r_state     <= ST_RD_DONE;
          end
        end

        ST_RD_DONE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_write_n   <= SIZE_NONE;
          r_read_n    <= SIZE_NONE;
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready              = r_req_ready;
  assign rsp_valid              = r_rsp_valid;
  assign rsp_rdata              = r_rsp_rdata;
  assign rsp_error              = r_rsp_error;
  assign bus_addr               = r_addr;
  assign bus_wdata              = r_wdata;
  assign bus_data_write_n       = r_write_n;
  assign bus_data_read_n        = r_read_n;
  assign bus_data_read_complete = r_complete;

endmodule

// File: tb/tb_tqv_peri_initiator.sv
// Self-checking bench for tqv_peri_initiator (TIMEOUT_CYCLES=4) with a simple peripheral model.
// Table of directed transactions plus hand sequences for response back-pressure and mid-read reset.
module tb_tqv_peri_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [10:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_data_write_n;
  logic [1:0]  bus_data_read_n;
  logic [31:0] bus_data_in;
  logic        bus_data_ready;
  logic        bus_data_read_complete;

  int checks = 0;
  int errors = 0;

  // Peripheral model: data_ready appears in the tb_delay-th read-wait cycle (0 = never).
  int          tb_delay = 0;
  logic [31:0] tb_pdata = '0;
  int          rd_cnt   = 0;

  tqv_peri_initiator #(
    .TIMEOUT_CYCLES(4),
    .TMO_W         (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_write             (req_write),
    .req_size              (req_size),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_rdata             (rsp_rdata),
    .rsp_error             (rsp_error),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_data_write_n      (bus_data_write_n),
    .bus_data_read_n       (bus_data_read_n),
    .bus_data_in           (bus_data_in),
    .bus_data_ready        (bus_data_ready),
    .bus_data_read_complete(bus_data_read_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_data_read_n != 2'b11) rd_cnt <= rd_cnt + 1;
    else                          rd_cnt <= 0;
  end

  assign bus_data_ready = (bus_data_read_n != 2'b11) && (tb_delay != 0) && (rd_cnt == tb_delay - 1);
  assign bus_data_in    = tb_pdata;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] pdata;
    int          n;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
    int          exp_cpl;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    check({tag, "_write_n"}, 32'(bus_data_write_n), 32'd3);
    check({tag, "_read_n"}, 32'(bus_data_read_n), 32'd3);
    check({tag, "_complete"}, 32'(bus_data_read_complete), 32'd0);
    check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
  endtask

  // Entered and left at a negedge with the DUT idle; rsp_ready is held at 1.
  task automatic do_txn(input int idx, input vec_t v);
    int lat, wr_cyc, rd_cyc, cpl, bad_strobe, bad_cpl, bad_ready;
    string p;
    p = $sformatf("v%0d", idx);
    lat = 0; wr_cyc = 0; rd_cyc = 0; cpl = 0; bad_strobe = 0; bad_cpl = 0; bad_ready = 0;
    tb_delay  = v.n;
    tb_pdata  = v.pdata;
    rsp_ready = 1'b1;
    req_write = v.wr;
    req_size  = v.sz;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    check({p, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (bus_data_write_n != 2'b11) begin
        wr_cyc++;
        if (bus_data_write_n != v.sz || bus_wdata != v.wdata || bus_addr != v.addr) bad_strobe++;
      end
      if (bus_data_read_n != 2'b11) begin
        rd_cyc++;
        if (bus_data_read_n != v.sz || bus_addr != v.addr) bad_strobe++;
      end
      if (bus_data_read_complete) begin
        cpl++;
        if (bus_data_read_n != 2'b11) bad_cpl++;
      end
      if (req_ready) bad_ready++;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({p, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({p, "_error"}, 32'(rsp_error), 32'(v.exp_err));
    check({p, "_addr_held"}, 32'(bus_addr), 32'(v.addr));
    check({p, "_wr_cycles"}, 32'(wr_cyc), 32'(v.exp_wr));
    check({p, "_rd_cycles"}, 32'(rd_cyc), 32'(v.exp_rd));
    check({p, "_cpl_pulses"}, 32'(cpl), 32'(v.exp_cpl));
    check({p, "_strobe_value"}, 32'(bad_strobe), 32'd0);
    check({p, "_cpl_read_n"}, 32'(bad_cpl), 32'd0);
    check({p, "_busy_req_ready"}, 32'(bad_ready), 32'd0);
    @(negedge clk);
    check({p, "_gap_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, "_gap_req_ready"}, 32'(req_ready), 32'd1);
    check({p, "_gap_bus_idle"}, 32'({bus_data_write_n, bus_data_read_n}), 32'hF);
  endtask

  initial begin
    int lat;
    //          wr    sz     addr     wdata          pdata          n  rdata          err  lat wr rd cpl
    vecs[0]  = '{1'b1, 2'b10, 11'h040, 32'h0000_00A5, 32'h0,         0, 32'h0,         1'b0, 2, 1, 0, 0};
    vecs[1]  = '{1'b0, 2'b00, 11'h044, 32'h0,         32'h1234_5678, 3, 32'h0000_0078, 1'b0, 5, 0, 3, 1};
    vecs[2]  = '{1'b0, 2'b10, 11'h100, 32'h0,         32'h5555_AAAA, 0, 32'h0,         1'b1, 6, 0, 4, 1};
    vecs[3]  = '{1'b0, 2'b10, 11'h100, 32'h0,         32'hCAFE_BABE, 2, 32'hCAFE_BABE, 1'b0, 4, 0, 2, 1};
    vecs[4]  = '{1'b1, 2'b01, 11'h010, 32'h0000_BEEF, 32'h0,         0, 32'h0,         1'b0, 2, 1, 0, 0};
    vecs[5]  = '{1'b0, 2'b01, 11'h012, 32'h0,         32'h89AB_CDEF, 4, 32'h0000_CDEF, 1'b0, 6, 0, 4, 1};
    vecs[6]  = '{1'b0, 2'b00, 11'h7FF, 32'h0,         32'hFFFF_FF80, 2, 32'h0000_0080, 1'b0, 4, 0, 2, 1};
    vecs[7]  = '{1'b0, 2'b11, 11'h020, 32'h0,         32'h1111_1111, 2, 32'h0,         1'b1, 1, 0, 0, 0};
    vecs[8]  = '{1'b1, 2'b11, 11'h024, 32'h0000_0042, 32'h0,         0, 32'h0,         1'b1, 1, 0, 0, 0};
`ifdef TQV_INIT_ALIGN_CHECK_EN
    vecs[9]  = '{1'b0, 2'b10, 11'h102, 32'h0,         32'h1122_3344, 2, 32'h0,         1'b1, 1, 0, 0, 0};
    vecs[10] = '{1'b1, 2'b01, 11'h013, 32'h0000_1234, 32'h0,         0, 32'h0,         1'b1, 1, 0, 0, 0};
`else
    vecs[9]  = '{1'b0, 2'b10, 11'h102, 32'h0,         32'h1122_3344, 2, 32'h1122_3344, 1'b0, 4, 0, 2, 1};
    vecs[10] = '{1'b1, 2'b01, 11'h013, 32'h0000_1234, 32'h0,         0, 32'h0,         1'b0, 2, 1, 0, 0};
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    for (int i = 0; i < NVEC; i++) do_txn(i, vecs[i]);

    // Response back-pressure: rsp_valid and rsp_rdata held while rsp_ready is low.
    tb_delay = 2; tb_pdata = 32'hDEAD_BEEF; rsp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'b10; req_addr = 11'h200; req_valid = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("hold_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("hold%0d_rsp_rdata", k), rsp_rdata, 32'hDEAD_BEEF);
      check($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("hold_release_rsp_rdata", rsp_rdata, 32'd0);
    check("hold_release_req_ready", 32'(req_ready), 32'd1);

    // Reset asserted while waiting for data_ready.
    tb_delay = 0; req_write = 1'b0; req_size = 2'b10; req_addr = 11'h300; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_read_active", 32'(bus_data_read_n), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(99, vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
